// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Sequences instruction fetches. It drives an external program counter
// (advance / load) and an instruction-memory request/ack handshake. It also
// handles branch and trap redirects while a memory request may still be in
// flight.
//
// States: IDLE (0), FETCH (1), HOLD (2, downstream stalled), DRAIN (3, a
// redirect happened while a request was in flight; wait for its ack and drop
// the instruction).
//
// Ports:
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   start_i            leave IDLE and begin fetching
//   halt_i             return to IDLE once nothing is outstanding
//   stall_i            downstream cannot accept an instruction
//   branch_valid_i     branch redirect request
//   branch_target_i    branch target address
//   trap_valid_i       trap redirect request (only with FETCH_SEQUENCER_TRAP_EN)
//   pc_current_i       current program counter value
//   imem_ack_i         memory completes the outstanding request
//   imem_req_o         memory request for pc_current_i
//   fetch_valid_o      acked instruction delivered downstream
//   pc_enable_o        advance the PC by one stride
//   pc_jump_o          load the PC with pc_jump_address_o
//   pc_jump_address_o  PC load value
//   epc_o              PC captured at the last accepted trap
//   state_o            current FSM state
//
// Build option: define FETCH_SEQUENCER_TRAP_EN to honour trap_valid_i and to
// capture the trapping PC into epc_o. When it is undefined, traps are ignored
// and epc_o is tied to 0.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = 'h100
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             stall_i,
  input  logic             branch_valid_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             trap_valid_i,
  input  logic [WIDTH-1:0] pc_current_i,
  input  logic             imem_ack_i,
  output logic             imem_req_o,
  output logic             fetch_valid_o,
  output logic             pc_enable_o,
  output logic             pc_jump_o,
  output logic [WIDTH-1:0] pc_jump_address_o,
  output logic [WIDTH-1:0] epc_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e           state_reg, state_next;
  logic             trap_eff;
  logic             redirect;
  logic [WIDTH-1:0] redirect_addr;
  logic             fetch_ack;

`ifdef FETCH_SEQUENCER_TRAP_EN
  assign trap_eff = trap_valid_i;
`else
  assign trap_eff = 1'b0;
  // The trap input and the PC input only matter when traps are enabled.
  logic unused_trap_inputs;
  assign unused_trap_inputs = ^{trap_valid_i, pc_current_i};
`endif

  // Trap wins over branch.
  assign redirect      = trap_eff | branch_valid_i;
  assign redirect_addr = trap_eff ? TRAP_VECTOR : branch_target_i;

  // In FETCH the request is only driven while not stalled. An ack that
  // arrives without a request is ignored.
  assign fetch_ack = imem_ack_i & ~stall_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    imem_req_o        = 1'b0;
    fetch_valid_o     = 1'b0;
    pc_enable_o       = 1'b0;
    pc_jump_o         = 1'b0;
    pc_jump_address_o = '0;

    unique case (state_reg)
      ST_IDLE: begin
        // Redirects are ignored here. A halt overrides a start.
        if (!halt_i && start_i) begin
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        imem_req_o = ~stall_i;
        if (redirect) begin
          // If an ack arrives in the same cycle, that instruction belongs
          // to the old path, so it is dropped.
          pc_jump_o         = 1'b1;
          pc_jump_address_o = redirect_addr;
        end else if (fetch_ack) begin
          fetch_valid_o = 1'b1;
          pc_enable_o   = 1'b1;
        end

        if (!stall_i && !imem_ack_i) begin
          // The request is still in flight, so a halt must wait. A redirect
          // has to drain the stale response first.
          if (redirect) begin
            state_next = ST_DRAIN;
          end
        end else if (halt_i) begin
          state_next = ST_IDLE;
        end else if (stall_i && !redirect) begin
          state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_jump_o         = 1'b1;
          pc_jump_address_o = redirect_addr;
        end
        if (halt_i) begin
          state_next = ST_IDLE;
        end else if (!stall_i) begin
          state_next = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        // Keep the stale request up until it is acked, and never deliver it.
        // Later redirects still load the PC, so the newest target wins.
        imem_req_o = 1'b1;
        if (redirect) begin
          pc_jump_o         = 1'b1;
          pc_jump_address_o = redirect_addr;
        end
        if (imem_ack_i) begin
          if (halt_i) begin
            state_next = ST_IDLE;
          end else if (stall_i) begin
            state_next = ST_HOLD;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

`ifdef FETCH_SEQUENCER_TRAP_EN
  logic [WIDTH-1:0] epc_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      epc_reg <= '0;
    end else if (trap_eff && state_reg != ST_IDLE) begin
      epc_reg <= pc_current_i;
    end
  end

  assign epc_o = epc_reg;
`else
  assign epc_o = '0;
`endif

  assign state_o = state_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Table-driven bench for fetch_sequencer. The bench contains a program
// counter that resets to 0 and advances by 1. Each table row gives the
// inputs for one cycle, the expected state and PC during that cycle, and the
// expected outputs. Inputs are driven at the falling edge and checked 2 time
// units later. Hand-written sequences follow for reset and for back-to-back
// redirects while in DRAIN.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

`ifdef FETCH_SEQUENCER_TRAP_EN
  localparam logic [31:0] PC_T  = 32'h100;
  localparam logic [31:0] EPC_T = 32'h7;
`else
  localparam logic [31:0] PC_T  = 32'h80;
  localparam logic [31:0] EPC_T = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, halt, stall, br, trap, ack;
  logic [31:0] target, pc;
  logic        req, fv, en, jmp;
  logic [31:0] addr, epc;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.WIDTH(32), .TRAP_VECTOR(32'h100)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .halt_i           (halt),
    .stall_i          (stall),
    .branch_valid_i   (br),
    .branch_target_i  (target),
    .trap_valid_i     (trap),
    .pc_current_i     (pc),
    .imem_ack_i       (ack),
    .imem_req_o       (req),
    .fetch_valid_o    (fv),
    .pc_enable_o      (en),
    .pc_jump_o        (jmp),
    .pc_jump_address_o(addr),
    .epc_o            (epc),
    .state_o          (state)
  );

  // Program counter model: RESET_VECTOR 0, STRIDE 1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pc <= 32'h0;
    else if (jmp) pc <= addr;
    else if (en)  pc <= pc + 32'h1;
  end

  typedef struct {
    logic [6:0]  in;     // {rst_n, start, halt, stall, branch, trap, ack}
    logic [31:0] tgt;
    logic [1:0]  e_state;
    logic [31:0] e_pc;
    logic [3:0]  e_out;  // {req, fetch_valid, pc_enable, pc_jump}
    logic [31:0] e_addr;
    logic [31:0] e_epc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [6:0] in, input logic [31:0] tgt,
                              input logic [1:0] st, input logic [31:0] p,
                              input logic [3:0] o, input logic [31:0] a,
                              input logic [31:0] e);
    vec_t v;
    v.in = in; v.tgt = tgt; v.e_state = st; v.e_pc = p;
    v.e_out = o; v.e_addr = a; v.e_epc = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic drive(input logic [6:0] in, input logic [31:0] tgt);
    {rst_n, start, halt, stall, br, trap, ack} = in;
    target = tgt;
  endtask

  initial begin
    // Startup: 4 acks, then an idle cycle in FETCH.
    vecs.push_back(mk(7'b1100000, 0, 0, 0, 4'b0000, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(7'b1000001, 0, 1, i, 4'b1110, 0, 0));
    vecs.push_back(mk(7'b1000000, 0, 1, 4, 4'b1000, 0, 0));
    // Reset again, then stall for 3 cycles at PC=2 (with an ack that must be ignored).
    vecs.push_back(mk(7'b0000000, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(7'b1100000, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(7'b1000001, 0, 1, 0, 4'b1110, 0, 0));
    vecs.push_back(mk(7'b1000001, 0, 1, 1, 4'b1110, 0, 0));
    vecs.push_back(mk(7'b1001001, 0, 1, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(7'b1001000, 0, 2, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(7'b1001000, 0, 2, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(7'b1000000, 0, 2, 2, 4'b0000, 0, 0));
    vecs.push_back(mk(7'b1000001, 0, 1, 2, 4'b1110, 0, 0));
    // Branch in the same cycle as an ack.
    vecs.push_back(mk(7'b1000101, 32'hABCD1234, 1, 3, 4'b1001, 32'hABCD1234, 0));
    vecs.push_back(mk(7'b1000000, 0, 1, 32'hABCD1234, 4'b1000, 0, 0));
    // Branch with the request outstanding: DRAIN, ack 2 cycles later.
    vecs.push_back(mk(7'b1000100, 32'h40, 1, 32'hABCD1234, 4'b1001, 32'h40, 0));
    vecs.push_back(mk(7'b1000000, 0, 3, 32'h40, 4'b1000, 0, 0));
    vecs.push_back(mk(7'b1000001, 0, 3, 32'h40, 4'b1000, 0, 0));
    vecs.push_back(mk(7'b1000001, 0, 1, 32'h40, 4'b1110, 0, 0));
    // Branch to PC=7, then trap and branch 'h80 together.
    vecs.push_back(mk(7'b1000101, 32'h7, 1, 32'h41, 4'b1001, 32'h7, 0));
    vecs.push_back(mk(7'b1000111, 32'h80, 1, 32'h7, 4'b1001, PC_T, 0));
    vecs.push_back(mk(7'b1000000, 0, 1, PC_T, 4'b1000, 0, EPC_T));
    // Enter DRAIN, then reset while in DRAIN with an ack present.
    vecs.push_back(mk(7'b1000100, 32'h20, 1, PC_T, 4'b1001, 32'h20, EPC_T));
    vecs.push_back(mk(7'b1000000, 0, 3, 32'h20, 4'b1000, 0, EPC_T));
    vecs.push_back(mk(7'b0000001, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(7'b1000000, 0, 0, 0, 4'b0000, 0, 0));
    // Halt over start; halt in FETCH waits for the ack.
    vecs.push_back(mk(7'b1110000, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(7'b1100000, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(7'b1010000, 0, 1, 0, 4'b1000, 0, 0));
    vecs.push_back(mk(7'b1010001, 0, 1, 0, 4'b1110, 0, 0));
    vecs.push_back(mk(7'b1000000, 0, 0, 1, 4'b0000, 0, 0));
    // Branch is ignored in IDLE.
    vecs.push_back(mk(7'b1000100, 32'h55, 0, 1, 4'b0000, 0, 0));
    // Halt during DRAIN only takes effect after the ack.
    vecs.push_back(mk(7'b1100000, 0, 0, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(7'b1010100, 32'h30, 1, 1, 4'b1001, 32'h30, 0));
    vecs.push_back(mk(7'b1010000, 0, 3, 32'h30, 4'b1000, 0, 0));
    vecs.push_back(mk(7'b1010001, 0, 3, 32'h30, 4'b1000, 0, 0));
    vecs.push_back(mk(7'b1000000, 0, 0, 32'h30, 4'b0000, 0, 0));

    // Outputs must be 0 while reset is asserted, with no clock edge needed.
    drive(7'b0111111, 32'hFFFFFFFF);
    #2;
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_outs", {28'd0, req, fv, en, jmp}, 32'd0);
    check("reset_addr_epc", addr | epc, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].in, vecs[i].tgt);
      #2;
      n_vec++;
      if (state !== vecs[i].e_state || pc !== vecs[i].e_pc ||
          {req, fv, en, jmp} !== vecs[i].e_out || addr !== vecs[i].e_addr ||
          epc !== vecs[i].e_epc) begin
        n_err++;
        $display("FAIL vec%0d: got st=%0d pc=%h rfej=%b addr=%h epc=%h, want st=%0d pc=%h rfej=%b addr=%h epc=%h",
                 i, state, pc, {req, fv, en, jmp}, addr, epc, vecs[i].e_state,
                 vecs[i].e_pc, vecs[i].e_out, vecs[i].e_addr, vecs[i].e_epc);
      end else begin
        $display("ok   vec%0d: st=%0d pc=%h rfej=%b addr=%h epc=%h",
                 i, state, pc, {req, fv, en, jmp}, addr, epc);
      end
    end

    // Two redirects in a row while in DRAIN: the newer target must win.
    @(negedge clk); drive(7'b1100000, 0);            // IDLE -> FETCH
    @(negedge clk); drive(7'b1000100, 32'h200);      // FETCH -> DRAIN, PC=200
    @(negedge clk); drive(7'b1000100, 32'h300);
    #2;
    check("drain_state", {30'd0, state}, 32'd3);
    check("drain_jump", {31'd0, jmp}, 32'd1);
    check("drain_addr", addr, 32'h300);
    @(negedge clk); drive(7'b1001001, 0);            // ack while stalled -> HOLD
    #2;
    check("drain_pc", pc, 32'h300);
    check("drain_ack_outs", {28'd0, req, fv, en, jmp}, 32'b1000);
    @(negedge clk); drive(7'b1001000, 0);
    #2;
    check("hold_state", {30'd0, state}, 32'd2);
    check("hold_req", {31'd0, req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning address width.
REQ-002 The module SHALL have parameter TRAP_VECTOR, default 'h100, meaning the redirect target on trap.
REQ-003 The module SHALL have port clk_i  input  1  clock; the only clock.
REQ-004 The module SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port start_i  input  1  leave IDLE and begin fetching.
REQ-006 The module SHALL have port halt_i  input  1  return to IDLE once no request is outstanding.
REQ-007 The module SHALL have port stall_i  input  1  downstream cannot accept an instruction.
REQ-008 The module SHALL have port branch_valid_i  input  1  branch redirect request.
REQ-009 The module SHALL have port branch_target_i  input  WIDTH  branch target address.
REQ-010 The module SHALL have port trap_valid_i  input  1  trap redirect request.
REQ-011 The module SHALL have port pc_current_i  input  WIDTH  current program counter value.
REQ-012 The module SHALL have port imem_ack_i  input  1  instruction memory completes the outstanding request.
REQ-013 The module SHALL have port imem_req_o  output  1  instruction memory request for pc_current_i.
REQ-014 The module SHALL have port fetch_valid_o  output  1  acked instruction is delivered downstream.
REQ-015 The module SHALL have port pc_enable_o  output  1  program counter advance by one stride.
REQ-016 The module SHALL have port pc_jump_o  output  1  program counter load.
REQ-017 The module SHALL have port pc_jump_address_o  output  WIDTH  program counter load value.
REQ-018 The module SHALL have port epc_o  output  WIDTH  PC captured at the last accepted trap.
REQ-019 The module SHALL have port state_o  output  2  FSM state: IDLE=0, FETCH=1, HOLD=2, DRAIN=3.

Function
REQ-020 The FSM SHALL use the four states listed in REQ-019; all outputs other than epc_o and state_o SHALL be combinational from state and inputs.
REQ-021 In IDLE, all request, valid and PC-control outputs SHALL be 0, and redirects SHALL be ignored; start_i=1 SHALL move to FETCH next cycle.
REQ-022 In FETCH, imem_req_o SHALL equal !stall_i; stall_i=1 without a redirect SHALL move to HOLD.
REQ-023 In FETCH, imem_ack_i=1 with no redirect SHALL assert fetch_valid_o and pc_enable_o in the same cycle (PC advances on that edge, zero added latency).
REQ-024 The redirect priority SHALL be trap > branch; a redirect SHALL assert pc_jump_o for one cycle with pc_jump_address_o = TRAP_VECTOR or branch_target_i, and pc_enable_o SHALL be 0 that cycle.
REQ-025 Redirect and ack in the same cycle SHALL suppress fetch_valid_o (the instruction is discarded), and the state SHALL remain FETCH.
REQ-026 A redirect in FETCH with the request outstanding and no ack SHALL move to DRAIN.
REQ-027 In DRAIN, imem_req_o SHALL stay 1 and fetch_valid_o SHALL stay 0; ack SHALL move to FETCH, or to HOLD if stall_i=1, with no pc_enable_o.
REQ-028 A further redirect in DRAIN SHALL be applied as in REQ-024, the newest target wins, and the state SHALL remain DRAIN until ack.
REQ-029 In HOLD, imem_req_o and pc_enable_o SHALL be 0, a redirect SHALL be applied, and stall_i=0 SHALL move to FETCH.
REQ-030 halt_i SHALL move to IDLE from HOLD, or from FETCH when no ack is pending.
REQ-031 In DRAIN, halt_i SHALL take effect only after the ack.
REQ-032 halt_i SHALL have priority over start_i.
REQ-033 When imem_ack_i arrives while imem_req_o=0, the block SHALL ignore it.

Reset
REQ-034 While rst_ni=0, the state SHALL be IDLE, epc_o SHALL be 0, and all outputs SHALL be 0, regardless of clk_i.
REQ-035 Reset mid-transaction SHALL abandon any outstanding request with no further output activity.

Configuration
REQ-036 With FETCH_SEQUENCER_TRAP_EN defined, trap_valid_i SHALL be honoured and an accepted trap SHALL capture pc_current_i into epc_o on that edge.
REQ-037 Without FETCH_SEQUENCER_TRAP_EN, trap_valid_i SHALL be ignored and epc_o SHALL be constant 0.

Verification (bench integrates a program counter with RESET_VECTOR 0, STRIDE 1)
REQ-038 The bench SHALL cover: reset, start_i, ack every cycle for 4 cycles -> four fetch_valid_o pulses, PC=4.
REQ-039 The bench SHALL cover: stall_i=1 for 3 cycles at PC=2 -> HOLD, imem_req_o=0, PC holds 2, FETCH resumes after release.
REQ-040 The bench SHALL cover: branch to 'hABCD1234 in the same cycle as ack -> fetch_valid_o=0, next PC='hABCD1234.
REQ-041 The bench SHALL cover: branch to 'h40 with the request outstanding, ack 2 cycles later -> DRAIN, no fetch_valid_o, PC='h40, then FETCH.
REQ-042 The bench SHALL cover: trap and branch 'h80 together at PC=7 with TRAP_EN -> PC='h100 and epc_o=7; without TRAP_EN -> PC='h80 and epc_o=0.
REQ-043 The bench SHALL cover: rst_ni low while in DRAIN -> all outputs 0 immediately and IDLE after release.
